// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - two-requester register-file write-back arbiter with pending-write scoreboard
module rf_wb_arbiter #(
    parameter int XLEN    = 32,
    parameter bit DROP_X0 = 1'b1
) (
    input  logic            clk,
    input  logic            areset,
    input  logic            stall,
    input  logic            req0_valid,
    input  logic [4:0]      req0_rd,
    input  logic [XLEN-1:0] req0_data,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [4:0]      req1_rd,
    input  logic [XLEN-1:0] req1_data,
    output logic            req1_ready,
    input  logic            busy_set,
    input  logic [4:0]      busy_rd,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [31:0]     pending
);

    logic            last_grant_q, last_grant_d;
    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic [31:0]     pending_q, pending_d;

    logic            grant0;
    logic            grant1;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;
    logic            forward;

    // last_grant_q names the requester served most recently; the other wins a tie.
    always_comb begin
        grant0   = !stall && req0_valid && (!req1_valid || last_grant_q);
        grant1   = !stall && req1_valid && (!req0_valid || !last_grant_q);
        sel_rd   = grant1 ? req1_rd : req0_rd;
        sel_data = grant1 ? req1_data : req0_data;
        forward  = (grant0 || grant1) && !(DROP_X0 && (sel_rd == 5'd0));

        last_grant_d = last_grant_q;
        if (grant0) begin
            last_grant_d = 1'b0;
        end
        if (grant1) begin
            last_grant_d = 1'b1;
        end

        rf_we_d    = forward;
        rf_waddr_d = forward ? sel_rd : rf_waddr_q;
        rf_wdata_d = forward ? sel_data : rf_wdata_q;

        // Clear first so a same-register set in the same cycle wins.
        pending_d = pending_q;
        if (rf_we_q) begin
            pending_d[rf_waddr_q] = 1'b0;
        end
        if (busy_set && (busy_rd != 5'd0)) begin
            pending_d[busy_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            last_grant_q <= 1'b1;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= 5'd0;
            rf_wdata_q   <= '0;
            pending_q    <= 32'd0;
        end else begin
            last_grant_q <= last_grant_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            pending_q    <= pending_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        areset;
    logic        stall;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_rd, req1_rd;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        busy_set;
    logic [4:0]  busy_rd;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pending;

    int n_cmp  = 0;
    int n_fail = 0;

    rf_wb_arbiter #(.XLEN(32), .DROP_X0(1'b1)) dut (
        .clk(clk), .areset(areset), .stall(stall),
        .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
        .busy_set(busy_set), .busy_rd(busy_rd),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: who was served last, what write is on the port, which registers are awaiting data.
    int          m_last;
    bit          m_we;
    int          m_waddr;
    logic [31:0] m_wdata;
    bit          m_pend [32];

    function automatic bit m_ready(input int who);
        bit mine, other;
        mine  = (who == 0) ? req0_valid : req1_valid;
        other = (who == 0) ? req1_valid : req0_valid;
        if (stall || !mine) return 1'b0;
        if (!other) return 1'b1;
        return who != m_last;
    endfunction

    always @(posedge clk or negedge areset) begin
        if (!areset) begin
            m_last  <= 1;
            m_we    <= 1'b0;
            m_waddr <= 0;
            m_wdata <= 32'd0;
            for (int i = 0; i < 32; i++) m_pend[i] <= 1'b0;
        end else begin
            int w;
            w = m_ready(0) ? 0 : (m_ready(1) ? 1 : -1);
            if (w >= 0) begin
                int rd;
                rd = (w == 0) ? int'(req0_rd) : int'(req1_rd);
                m_last <= w;
                m_we   <= (rd != 0);
                if (rd != 0) begin
                    m_waddr <= rd;
                    m_wdata <= (w == 0) ? req0_data : req1_data;
                end
            end else begin
                m_we <= 1'b0;
            end
            for (int i = 1; i < 32; i++) begin
                if (busy_set && int'(busy_rd) == i) m_pend[i] <= 1'b1;
                else if (m_we && m_waddr == i) m_pend[i] <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] ep;
        for (int i = 0; i < 32; i++) ep[i] = m_pend[i];
        chk("req0_ready", 64'(req0_ready), 64'(m_ready(0)));
        chk("req1_ready", 64'(req1_ready), 64'(m_ready(1)));
        chk("rf_we", 64'(rf_we), 64'(m_we));
        chk("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
        chk("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
        chk("pending", 64'(pending), 64'(ep));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; req0_valid = 0; req1_valid = 0; busy_set = 0;
        req0_rd = 0; req1_rd = 0; req0_data = 0; req1_data = 0; busy_rd = 0;
    endtask

    task automatic reset_pulse();
        areset = 0;
        tick();
        areset = 1;
    endtask

    initial begin
        areset = 0;
        idle_inputs();
        #1;
        chk("reset_async_we", 64'(rf_we), 64'd0);
        chk("reset_async_pending", 64'(pending), 64'd0);
        tick();
        tick();
        areset = 1;

        // Single ALU write, one-cycle latency
        req0_valid = 1; req0_rd = 5; req0_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("t034_ready0", 64'(req0_ready), 64'd1);
        tick();
        req0_valid = 0;
        @(negedge clk);
        chk("t034_we", 64'(rf_we), 64'd1);
        chk("t034_waddr", 64'(rf_waddr), 64'd5);
        chk("t034_wdata", 64'(rf_wdata), 64'hDEADBEEF);
        tick();

        // Contention after reset alternates starting with requester 0
        reset_pulse();
        req0_valid = 1; req0_rd = 1; req0_data = 32'hA1;
        req1_valid = 1; req1_rd = 2; req1_data = 32'hB2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t035_grant0", 64'(req0_ready), 64'((i % 2) == 0));
            chk("t035_grant1", 64'(req1_ready), 64'((i % 2) == 1));
            if (i > 0) chk("t035_waddr", 64'(rf_waddr), (((i - 1) % 2) == 0) ? 64'd1 : 64'd2);
            tick();
        end
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        chk("t035_last_waddr", 64'(rf_waddr), 64'd2);
        chk("t035_last_wdata", 64'(rf_wdata), 64'hB2);
        tick();

        // Scoreboard set then cleared by the load write-back
        busy_set = 1; busy_rd = 7;
        tick();
        busy_set = 0;
        @(negedge clk);
        chk("t036_pend_set", 64'(pending[7]), 64'd1);
        tick();
        req1_valid = 1; req1_rd = 7; req1_data = 32'h77;
        @(negedge clk);
        chk("t036_ready1", 64'(req1_ready), 64'd1);
        tick();
        req1_valid = 0;
        @(negedge clk);
        chk("t036_we", 64'(rf_we), 64'd1);
        chk("t036_pend_held", 64'(pending[7]), 64'd1);
        tick();
        @(negedge clk);
        chk("t036_pend_clr", 64'(pending[7]), 64'd0);
        tick();

        // Set wins over a clear of the same register
        req0_valid = 1; req0_rd = 9; req0_data = 32'h99;
        tick();
        req0_valid = 0; busy_set = 1; busy_rd = 9;
        @(negedge clk);
        chk("t037_we", 64'(rf_we), 64'd1);
        tick();
        busy_set = 0;
        @(negedge clk);
        chk("t037_pend", 64'(pending[9]), 64'd1);
        tick();

        // Writes and busy marks to x0 are swallowed
        req0_valid = 1; req0_rd = 0; req0_data = 32'h1234;
        @(negedge clk);
        chk("t038_ready0", 64'(req0_ready), 64'd1);
        tick();
        req0_valid = 0; busy_set = 1; busy_rd = 0;
        @(negedge clk);
        chk("t038_we", 64'(rf_we), 64'd0);
        tick();
        busy_set = 0;
        @(negedge clk);
        chk("t038_pend0", 64'(pending[0]), 64'd0);
        chk("t038_pend", 64'(pending), 64'h0000_0200);
        tick();

        // Stall blocks both requesters
        stall = 1; req0_valid = 1; req0_rd = 3; req1_valid = 1; req1_rd = 4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t039_stall_r0", 64'(req0_ready), 64'd0);
            chk("t039_stall_r1", 64'(req1_ready), 64'd0);
            tick();
            chk("t039_stall_we", 64'(rf_we), 64'd0);
        end
        stall = 0;
        @(negedge clk);
        #1;
        areset = 0;
        #1;
        chk("t039_rst_we", 64'(rf_we), 64'd0);
        chk("t039_rst_waddr", 64'(rf_waddr), 64'd0);
        chk("t039_rst_wdata", 64'(rf_wdata), 64'd0);
        chk("t039_rst_pend", 64'(pending), 64'd0);
        tick();
        areset = 1;
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        chk("t039_no_spurious_we", 64'(rf_we), 64'd0);
        tick();

        // Mixed traffic, checked by the model every cycle
        for (int i = 0; i < 60; i++) begin
            stall      = ($urandom_range(0, 5) == 0);
            req0_valid = $urandom_range(0, 1);
            req1_valid = $urandom_range(0, 1);
            req0_rd    = 5'($urandom_range(0, 31));
            req1_rd    = 5'($urandom_range(0, 31));
            req0_data  = $urandom;
            req1_data  = $urandom;
            busy_set   = $urandom_range(0, 1);
            busy_rd    = 5'($urandom_range(0, 31));
            tick();
        end
        idle_inputs();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
